carfield_region_decoder: RTL and testbench

- Runtime-programmable successor to the static Carfield address-map configuration.
- Holds NumRegions base/size/enable entries, initialised from parameters and reprogrammable through a config port until the map is locked.
- Decodes request addresses into a region index or a decode error, through one registered pipeline stage.
- Counts outstanding transactions per region, so disabling a region drains safely before the region is reported idle.

---
 rtl/carfield_region_decoder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_carfield_region_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_region_decoder.sv
// ---------------------------------------------------------------------------
// carfield_region_decoder
//
// Runtime-programmable address-map decoder. Holds NumRegions base/size
// entries, each with an OFF/ON/DRAIN state. Entries start from parameter
// defaults and can be rewritten through the config port until the map is
// locked. Request addresses are decoded into a region index or a decode
// error through one registered pipeline stage. Per-region outstanding
// counters let a disabled region drain before it is reported idle.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   cfg_valid_i         config write strobe (cfg_ready_o is always 1)
//   cfg_idx_i           target region
//   cfg_sel_i           0 base, 1 size, 2 enable (wdata[0]), 3 lock
//   cfg_wdata_i         write data
//   cfg_err_o           one-cycle pulse: the previous write was rejected
//   req_valid_i/_ready_o/req_addr_i     decode request handshake
//   rsp_valid_o/rsp_ready_i             decode result handshake
//   rsp_idx_o, rsp_hit_o, rsp_decerr_o  decode result (idx 0 on miss)
//   done_valid_i, done_idx_i            transaction completion
//   region_en_o         per-region state == ON
//   region_busy_o       per-region outstanding count != 0
//   locked_o            map locked
// ---------------------------------------------------------------------------
module carfield_region_decoder #(
  parameter int unsigned NumRegions     = 8,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 15,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionBaseRst = '0,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RegionSizeRst = '0,
  parameter logic [NumRegions-1:0]                RegionEnRst   = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [$clog2(NumRegions)-1:0] cfg_idx_i,
  input  logic [1:0]                    cfg_sel_i,
  input  logic [AddrWidth-1:0]          cfg_wdata_i,
  output logic                          cfg_err_o,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AddrWidth-1:0]          req_addr_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NumRegions)-1:0] rsp_idx_o,
  output logic                          rsp_hit_o,
  output logic                          rsp_decerr_o,
  input  logic                          done_valid_i,
  input  logic [$clog2(NumRegions)-1:0] done_idx_i,
  output logic [NumRegions-1:0]         region_en_o,
  output logic [NumRegions-1:0]         region_busy_o,
  output logic                          locked_o
);

  localparam int unsigned IdxW = $clog2(NumRegions);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_DRAIN = 2'd2
  } region_state_e;

  // Map and per-region bookkeeping
  logic [AddrWidth-1:0] base_r      [NumRegions];
  logic [AddrWidth-1:0] size_r      [NumRegions];
  region_state_e        state_r     [NumRegions];
  region_state_e        state_nxt_s [NumRegions];
  logic [CntW-1:0]      cnt_r       [NumRegions];
  logic [CntW-1:0]      cnt_nxt_s   [NumRegions];
  logic [NumRegions-1:0] base_we_s;
  logic [NumRegions-1:0] size_we_s;
  logic [NumRegions-1:0] en_we_s;

  // Decode path
  logic [NumRegions-1:0] match_s;
  logic                  hit_s;
  logic                  found_s;
  logic [IdxW-1:0]       hit_idx_s;
  logic                  sat_s;
  logic                  req_ready_s;
  logic                  req_fire_s;

  // Config path
  logic                  idx_ok_s;
  logic                  cfg_ok_s;
  region_state_e         cfg_state_s;
  logic                  locked_r;
  logic                  cfg_err_r;

  // Response registers
  logic                  rsp_valid_r;
  logic                  rsp_hit_r;
  logic                  rsp_decerr_r;
  logic [IdxW-1:0]       rsp_idx_r;

  // Per-region address match against the current (pre-write) map
  always_comb begin
    match_s = '0;
    for (int r = 0; r < NumRegions; r++) begin
      // Subtraction only evaluated meaningfully when addr >= base, so the
      // window test never wraps.
      if ((state_r[r] == ST_ON) && (size_r[r] != '0) &&
          (req_addr_i >= base_r[r]) && ((req_addr_i - base_r[r]) < size_r[r])) begin
        match_s[r] = 1'b1;
      end else begin
        match_s[r] = 1'b0;
      end
    end
  end

  // Lowest-index priority among matching regions
  always_comb begin
    found_s   = 1'b0;
    hit_idx_s = '0;
    for (int r = 0; r < NumRegions; r++) begin
      hit_idx_s = (match_s[r] && !found_s) ? IdxW'(r) : hit_idx_s;
      found_s   = found_s | match_s[r];
    end
    hit_s = found_s;
  end

  // Request handshake: stall on a full output slot or a saturated region
  always_comb begin
    sat_s       = hit_s && (cnt_r[hit_idx_s] == CntW'(MaxOutstanding));
    req_ready_s = (!rsp_valid_r || rsp_ready_i) && !sat_s;
    req_fire_s  = req_valid_i && req_ready_s;
  end

  // Config write legality check
  always_comb begin
    idx_ok_s    = ({1'b0, cfg_idx_i} < (IdxW + 1)'(NumRegions));
    cfg_state_s = state_r[cfg_idx_i];
    cfg_ok_s    = 1'b0;
    if (!cfg_valid_i || locked_r || !idx_ok_s) begin
      cfg_ok_s = 1'b0;
    end else begin
      case (cfg_sel_i)
        2'd0, 2'd1: cfg_ok_s = (cfg_state_s == ST_OFF);
        2'd2:       cfg_ok_s = !(cfg_wdata_i[0] && (cfg_state_s == ST_DRAIN));
        2'd3:       cfg_ok_s = 1'b1;
        default:    cfg_ok_s = 1'b0;
      endcase
    end
  end

  // Per-region write enables, counter and state next-values
  always_comb begin
    for (int r = 0; r < NumRegions; r++) begin
      base_we_s[r] = cfg_ok_s && (cfg_sel_i == 2'd0) && (cfg_idx_i == IdxW'(r));
      size_we_s[r] = cfg_ok_s && (cfg_sel_i == 2'd1) && (cfg_idx_i == IdxW'(r));
      en_we_s[r]   = cfg_ok_s && (cfg_sel_i == 2'd2) && (cfg_idx_i == IdxW'(r));

      // A done on an idle counter is ignored; +1 and -1 together cancel.
      if ((req_fire_s && hit_s && (hit_idx_s == IdxW'(r))) &&
          !(done_valid_i && (done_idx_i == IdxW'(r)) && (cnt_r[r] != '0))) begin
        cnt_nxt_s[r] = cnt_r[r] + CntW'(1);
      end else if (!(req_fire_s && hit_s && (hit_idx_s == IdxW'(r))) &&
                   (done_valid_i && (done_idx_i == IdxW'(r)) && (cnt_r[r] != '0))) begin
        cnt_nxt_s[r] = cnt_r[r] - CntW'(1);
      end else begin
        cnt_nxt_s[r] = cnt_r[r];
      end

      state_nxt_s[r] = state_r[r];
      case (state_r[r])
        ST_OFF: begin
          if (en_we_s[r] && cfg_wdata_i[0]) begin
            state_nxt_s[r] = ST_ON;
          end else begin
            state_nxt_s[r] = ST_OFF;
          end
        end
        ST_ON: begin
          // Use the next count so a same-cycle hit keeps the region draining.
          if (en_we_s[r] && !cfg_wdata_i[0]) begin
            state_nxt_s[r] = (cnt_nxt_s[r] != '0) ? ST_DRAIN : ST_OFF;
          end else begin
            state_nxt_s[r] = ST_ON;
          end
        end
        ST_DRAIN: begin
          if (cnt_r[r] == '0) begin
            state_nxt_s[r] = ST_OFF;
          end else begin
            state_nxt_s[r] = ST_DRAIN;
          end
        end
        default: state_nxt_s[r] = ST_OFF;
      endcase
    end
  end

  // Map entries, region states and outstanding counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NumRegions; r++) begin
        base_r[r]  <= RegionBaseRst[r];
        size_r[r]  <= RegionSizeRst[r];
        state_r[r] <= RegionEnRst[r] ? ST_ON : ST_OFF;
        cnt_r[r]   <= '0;
      end
    end else begin
      for (int r = 0; r < NumRegions; r++) begin
        cnt_r[r]   <= cnt_nxt_s[r];
        state_r[r] <= state_nxt_s[r];
        if (base_we_s[r]) begin
          base_r[r] <= cfg_wdata_i;
        end
        if (size_we_s[r]) begin
          size_r[r] <= cfg_wdata_i;
        end
      end
    end
  end

  // Lock flag and rejected-write pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked_r  <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_valid_i && !cfg_ok_s;
      if (cfg_ok_s && (cfg_sel_i == 2'd3)) begin
        locked_r <= 1'b1;
      end
    end
  end

  // Decode response stage; holds while the consumer stalls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_r  <= 1'b0;
      rsp_hit_r    <= 1'b0;
      rsp_decerr_r <= 1'b0;
      rsp_idx_r    <= '0;
    end else if (req_fire_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_hit_r    <= hit_s;
      rsp_decerr_r <= !hit_s;
      rsp_idx_r    <= hit_idx_s;
    end else if (rsp_ready_i) begin
      rsp_valid_r  <= 1'b0;
    end
  end

  // Status outputs decoded from registered state
  always_comb begin
    for (int r = 0; r < NumRegions; r++) begin
      region_en_o[r]   = (state_r[r] == ST_ON);
      region_busy_o[r] = (cnt_r[r] != '0);
    end
  end

  assign cfg_ready_o  = 1'b1;
  assign cfg_err_o    = cfg_err_r;
  assign locked_o     = locked_r;
  assign req_ready_o  = req_ready_s;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_hit_o    = rsp_hit_r;
  assign rsp_decerr_o = rsp_decerr_r;
  assign rsp_idx_o    = rsp_idx_r;

endmodule

// File: tb/tb_carfield_region_decoder.sv
// ---------------------------------------------------------------------------
// tb_carfield_region_decoder
//
// Self-checking bench: a vector table for the decode function plus hand
// sequences for draining, saturation, illegal writes and backpressure with
// asynchronous reset. Accepted requests push their expected result into a
// scoreboard queue; delivered responses pop and compare.
// ---------------------------------------------------------------------------
module tb_carfield_region_decoder;

  localparam logic [7:0][63:0] BASE_RST = {64'h0000_0000_9000_0000, {7{64'h0}}};
  localparam logic [7:0][63:0] SIZE_RST = {64'h0000_0000_0000_1000, {7{64'h0}}};
  localparam logic [7:0]       EN_RST   = 8'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_idx = 3'd0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [63:0] cfg_wdata = 64'd0;
  logic        cfg_err;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_idx;
  logic        rsp_hit;
  logic        rsp_decerr;
  logic        done_valid = 1'b0;
  logic [2:0]  done_idx = 3'd0;
  logic [7:0]  region_en;
  logic [7:0]  region_busy;
  logic        locked;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected result of the request currently driven
  logic       exp_hit = 1'b0;
  logic [2:0] exp_idx = 3'd0;
  logic       exp_lat = 1'b1;

  typedef struct {
    logic       hit;
    logic [2:0] idx;
    int         cyc;
    logic       lat;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [63:0] addr;
    logic        hit;
    logic [2:0]  idx;
  } vec_t;
  vec_t vecs[11];

  carfield_region_decoder #(
    .NumRegions     (8),
    .AddrWidth      (64),
    .MaxOutstanding (15),
    .RegionBaseRst  (BASE_RST),
    .RegionSizeRst  (SIZE_RST),
    .RegionEnRst    (EN_RST)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_idx_i     (cfg_idx),
    .cfg_sel_i     (cfg_sel),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_err_o     (cfg_err),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_idx_o     (rsp_idx),
    .rsp_hit_o     (rsp_hit),
    .rsp_decerr_o  (rsp_decerr),
    .done_valid_i  (done_valid),
    .done_idx_i    (done_idx),
    .region_en_o   (region_en),
    .region_busy_o (region_busy),
    .locked_o      (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop on delivered response, push on accepted request
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbq.delete();
    end else begin
      sb_t e;
      cyc++;
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_hit", {63'd0, rsp_hit}, {63'd0, e.hit});
          chk("rsp_decerr", {63'd0, rsp_decerr}, {63'd0, !e.hit});
          chk("rsp_idx", {61'd0, rsp_idx}, {61'd0, e.idx});
          if (e.lat) chk("rsp_latency", 64'(cyc), 64'(e.cyc + 1));
        end
      end
      if (req_valid && req_ready) begin
        e.hit = exp_hit; e.idx = exp_idx; e.cyc = cyc; e.lat = exp_lat;
        sbq.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [2:0] idx, input logic [1:0] sel,
                        input logic [63:0] data, input logic err);
    cfg_valid = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = data;
    step();
    cfg_valid = 1'b0;
    chk("cfg_err", {63'd0, cfg_err}, {63'd0, err});
  endtask

  task automatic send(input logic [63:0] a, input logic h, input logic [2:0] i);
    int n = 0;
    req_addr = a; exp_hit = h; exp_idx = i; req_valid = 1'b1;
    #1;
    while (!req_ready && n < 64) begin
      step();
      n++;
    end
    if (!req_ready) chk("req_timeout", 64'd0, 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic done(input logic [2:0] i);
    done_valid = 1'b1; done_idx = i;
    step();
    done_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{64'h7800_0000, 1'b1, 3'd0};
    vecs[1]  = '{64'h7801_FFFF, 1'b1, 3'd0};
    vecs[2]  = '{64'h7802_0000, 1'b0, 3'd0};
    vecs[3]  = '{64'h5000_0800, 1'b1, 3'd1};
    vecs[4]  = '{64'h5000_0000, 1'b1, 3'd1};
    vecs[5]  = '{64'h507F_FFFF, 1'b1, 3'd1};
    vecs[6]  = '{64'h5080_0000, 1'b0, 3'd0};
    vecs[7]  = '{64'h77FF_FFFF, 1'b0, 3'd0};
    vecs[8]  = '{64'h9000_0000, 1'b1, 3'd7};
    vecs[9]  = '{64'h9000_0FFF, 1'b1, 3'd7};
    vecs[10] = '{64'h9000_1000, 1'b0, 3'd0};

    // Reset state
    step(); step();
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
    chk("rst_region_en", {56'd0, region_en}, 64'h80);
    chk("rst_region_busy", {56'd0, region_busy}, 64'h0);
    chk("cfg_ready", {63'd0, cfg_ready}, 64'd1);
    rst = 1'b0;
    step();

    // Program regions 0, 1, 2
    cfg_wr(3'd0, 2'd0, 64'h7800_0000, 1'b0);
    cfg_wr(3'd0, 2'd1, 64'h0002_0000, 1'b0);
    cfg_wr(3'd0, 2'd2, 64'd1, 1'b0);
    cfg_wr(3'd1, 2'd0, 64'h5000_0000, 1'b0);
    cfg_wr(3'd1, 2'd1, 64'h0080_0000, 1'b0);
    cfg_wr(3'd1, 2'd2, 64'd1, 1'b0);
    cfg_wr(3'd2, 2'd0, 64'h5000_0000, 1'b0);
    cfg_wr(3'd2, 2'd1, 64'h0000_1000, 1'b0);
    cfg_wr(3'd2, 2'd2, 64'd1, 1'b0);
    chk("prog_region_en", {56'd0, region_en}, 64'h87);

    // Vector table, back-to-back
    for (int v = 0; v < 11; v++) send(vecs[v].addr, vecs[v].hit, vecs[v].idx);
    step();
    chk("table_busy", {56'd0, region_busy}, 64'h83);
    done(3'd0); done(3'd0);
    done(3'd1); done(3'd1); done(3'd1);
    done(3'd7); done(3'd7);
    done(3'd3);
    chk("table_idle", {56'd0, region_busy}, 64'h0);

    // Drain: third hit lands in the same cycle as the disable write
    send(64'h5000_0010, 1'b1, 3'd1);
    send(64'h5000_0010, 1'b1, 3'd1);
    cfg_valid = 1'b1; cfg_idx = 3'd1; cfg_sel = 2'd2; cfg_wdata = 64'd0;
    send(64'h5000_0010, 1'b1, 3'd1);
    cfg_valid = 1'b0;
    chk("drain_en1", {63'd0, region_en[1]}, 64'd0);
    chk("drain_busy1", {63'd0, region_busy[1]}, 64'd1);
    send(64'h5010_0000, 1'b0, 3'd0);
    cfg_wr(3'd1, 2'd2, 64'd1, 1'b1);
    chk("drain_en_rejected", {63'd0, region_en[1]}, 64'd0);
    done(3'd1); done(3'd1);
    chk("drain_busy_2left", {63'd0, region_busy[1]}, 64'd1);
    done(3'd1);
    chk("drain_busy_clear", {63'd0, region_busy[1]}, 64'd0);
    cfg_wr(3'd1, 2'd1, 64'h0080_0000, 1'b1);
    cfg_wr(3'd1, 2'd1, 64'h0080_0000, 1'b0);
    cfg_wr(3'd1, 2'd2, 64'd1, 1'b0);
    chk("drain_reenabled", {56'd0, region_en}, 64'h87);

    // Saturation of region 0
    for (int k = 0; k < 15; k++) send(64'h7800_0100, 1'b1, 3'd0);
    req_addr = 64'h7802_0000;
    #1;
    chk("sat_miss_ready", {63'd0, req_ready}, 64'd1);
    req_addr = 64'h7800_0200; exp_hit = 1'b1; exp_idx = 3'd0; req_valid = 1'b1;
    done_valid = 1'b1; done_idx = 3'd0;
    #1;
    chk("sat_ready", {63'd0, req_ready}, 64'd0);
    step();
    done_valid = 1'b0;
    #1;
    chk("sat_ready_after_done", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 15; k++) done(3'd0);
    chk("sat_idle", {56'd0, region_busy}, 64'h0);

    // Illegal writes and lock
    cfg_wr(3'd0, 2'd1, 64'h1234, 1'b1);
    step();
    chk("err_pulse_once", {63'd0, cfg_err}, 64'd0);
    cfg_wr(3'd0, 2'd3, 64'd0, 1'b0);
    chk("locked", {63'd0, locked}, 64'd1);
    cfg_wr(3'd3, 2'd0, 64'h1000, 1'b1);
    cfg_wr(3'd0, 2'd3, 64'd0, 1'b1);
    cfg_wr(3'd3, 2'd2, 64'd1, 1'b1);
    chk("lock_map_en", {56'd0, region_en}, 64'h87);
    send(64'h7801_FFFF, 1'b1, 3'd0);
    send(64'h7802_0000, 1'b0, 3'd0);
    step();
    done(3'd0);

    // Backpressure, then asynchronous reset mid-stall
    rsp_ready = 1'b0;
    send(64'h7800_0000, 1'b1, 3'd0);
    req_addr = 64'h7800_0004; req_valid = 1'b1; exp_lat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
      chk("stall_hit_idx", {60'd0, rsp_hit, rsp_idx}, {60'd0, 1'b1, 3'd0});
      chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
      step();
    end
    #2;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("arst_busy", {56'd0, region_busy}, 64'h0);
    chk("arst_region_en", {56'd0, region_en}, 64'h80);
    chk("arst_locked", {63'd0, locked}, 64'd0);
    step(); step();
    rst = 1'b0; rsp_ready = 1'b1; exp_lat = 1'b1;
    step();
    send(64'h7800_0000, 1'b0, 3'd0);
    send(64'h9000_0010, 1'b1, 3'd7);
    step(); step();
    cfg_wr(3'd0, 2'd0, 64'h1000, 1'b0);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
